audio_nios_onchip_ram_pipelined: RTL and testbench

Parametrised Avalon-MM single-port on-chip RAM slave for the audio Nios subsystem, successor to the fixed 32-bit × 51200 single-cycle memory. It adds configurable width, depth and read latency, `waitrequest`/`readdatavalid` handshaking, and a hardware clear engine that zeroes the array after reset. It optionally stores per-byte parity and flags read errors. It sits on the Nios data master interconnect as instruction, data or audio-buffer memory.

---
 rtl/audio_nios_onchip_ram_pipelined_if.sv | 28 ++
 rtl/audio_nios_onchip_ram_pipelined.sv | 176 +++++++++++++++++
 tb/tb_audio_nios_onchip_ram_pipelined.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/audio_nios_onchip_ram_pipelined_if.sv
// Avalon-MM slave bus bundle for audio_nios_onchip_ram_pipelined.
// Handshake: a transfer is accepted on a rising edge where chipselect & (read|write) & !waitrequest;
// every accepted read returns exactly one readdatavalid beat, in request order.
interface audio_nios_onchip_ram_pipelined_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16
);
    logic                    chipselect;
    logic                    read;
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH/8-1:0] byteenable;
    logic [DATA_WIDTH-1:0]   writedata;
    logic [DATA_WIDTH-1:0]   readdata;
    logic                    readdatavalid;
    logic                    waitrequest;
    logic                    parity_error;

    modport master (
        output chipselect, read, write, address, byteenable, writedata,
        input  readdata, readdatavalid, waitrequest, parity_error
    );

    modport slave (
        input  chipselect, read, write, address, byteenable, writedata,
        output readdata, readdatavalid, waitrequest, parity_error
    );
endinterface

// File: rtl/audio_nios_onchip_ram_pipelined.sv
// Avalon-MM single-port on-chip RAM with configurable read latency and a post-reset clear engine.
// Optional per-byte even parity storage and checking is enabled by defining AUDIO_NIOS_RAM_PARITY_EN.
module audio_nios_onchip_ram_pipelined #(
    parameter int    DATA_WIDTH     = 32,
    parameter int    DEPTH          = 51200,
    parameter int    ADDR_WIDTH     = 16,
    parameter int    READ_LATENCY   = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = "audio_nios_onchip_ram_pipelined.hex"
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              clken,
    audio_nios_onchip_ram_pipelined_if.slave  bus,
    output logic [1:0]                        state_dbg
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_CLEAR = 2'd1,
        ST_READY = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [IDX_W-1:0]       clear_cnt_q, clear_cnt_d;
    logic                   clear_we;
    logic                   waitrequest;
    logic                   in_range;
    logic [IDX_W-1:0]       idx;
    logic                   wr_acc, rd_acc;
    logic [DATA_WIDTH-1:0]  rd_data;
    logic                   rd_err;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_RESET;
            clear_cnt_q <= '0;
        end else if (clken) begin
            state_q     <= state_d;
            clear_cnt_q <= clear_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        clear_cnt_d = clear_cnt_q;
        clear_we    = 1'b0;
        case (state_q)
            ST_RESET: begin
                clear_cnt_d = '0;
                state_d     = CLEAR_ON_RESET ? ST_CLEAR : ST_READY;
            end
            ST_CLEAR: begin
                clear_we = 1'b1;
                if (clear_cnt_q == IDX_W'(DEPTH - 1))
                    state_d = ST_READY;
                else
                    clear_cnt_d = clear_cnt_q + IDX_W'(1);
            end
            ST_READY: state_d = ST_READY;
            default:  state_d = ST_RESET;
        endcase
    end

    assign state_dbg   = state_q;
    assign waitrequest = reset | (state_q != ST_READY) | !clken;

    // ---------------- request decode ----------------
    assign in_range = ({1'b0, bus.address} < (ADDR_WIDTH + 1)'(DEPTH));
    assign idx      = bus.address[IDX_W-1:0];
    assign wr_acc   = bus.chipselect & bus.write & !waitrequest;
    // A simultaneous read+write performs only the write; the read never enters the pipeline.
    assign rd_acc   = bus.chipselect & bus.read & !bus.write & !waitrequest;

    // ---------------- storage ----------------
    always_ff @(posedge clk) begin
        if (clear_we && clken && !reset) begin
            mem[clear_cnt_q] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.byteenable[i])
                    mem[idx][8*i +: 8] <= bus.writedata[8*i +: 8];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        if (in_range)
            rd_data = mem[idx];
    end

`ifdef AUDIO_NIOS_RAM_PARITY_EN
    logic [BYTES-1:0] par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (clear_we && clken && !reset) begin
            par_mem[clear_cnt_q] <= '0;
        end else if (wr_acc && in_range) begin
            for (int i = 0; i < BYTES; i++) begin
                if (bus.byteenable[i])
                    par_mem[idx][i] <= ^bus.writedata[8*i +: 8];
            end
        end
    end

    // Out-of-range reads never flag an error.
    always_comb begin
        rd_err = 1'b0;
        if (in_range) begin
            for (int i = 0; i < BYTES; i++)
                rd_err = rd_err | (par_mem[idx][i] != ^mem[idx][8*i +: 8]);
        end
    end
`else
    assign rd_err = 1'b0;
`endif

    // ---------------- read pipeline ----------------
    logic                  s1_v, s1_e;
    logic [DATA_WIDTH-1:0] s1_d;
    logic                  out_v, out_e;
    logic [DATA_WIDTH-1:0] out_d;
    logic                  beat;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_v <= 1'b0;
            s1_d <= '0;
            s1_e <= 1'b0;
        end else if (clken) begin
            s1_v <= rd_acc;
            s1_d <= rd_acc ? rd_data : '0;
            s1_e <= rd_acc & rd_err;
        end
    end

    generate
        if (READ_LATENCY >= 2) begin : g_lat2
            logic                  s2_v, s2_e;
            logic [DATA_WIDTH-1:0] s2_d;

            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_v <= 1'b0;
                    s2_d <= '0;
                    s2_e <= 1'b0;
                end else if (clken) begin
                    s2_v <= s1_v;
                    s2_d <= s1_d;
                    s2_e <= s1_e;
                end
            end

            assign out_v = s2_v;
            assign out_d = s2_d;
            assign out_e = s2_e;
        end else begin : g_lat1
            assign out_v = s1_v;
            assign out_d = s1_d;
            assign out_e = s1_e;
        end
    endgenerate

    // A frozen pipeline holds its last stage; the beat is shown only on an enabled cycle.
    assign beat              = out_v & clken & !reset;
    assign bus.readdatavalid = beat;
    assign bus.readdata      = beat ? out_d : '0;
    assign bus.parity_error  = beat & out_e;
    assign bus.waitrequest   = waitrequest;
endmodule

// File: tb/tb_audio_nios_onchip_ram_pipelined.sv
// Directed bench for audio_nios_onchip_ram_pipelined: one latency-1 and one latency-2 instance
// share stimulus; read beats are collected by a monitor and compared against expected queues.
module tb_audio_nios_onchip_ram_pipelined;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 16;
    localparam int BE    = DW / 8;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          clken = 1'b1;
    logic          cs    = 1'b0;
    logic          rd    = 1'b0;
    logic          wr    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [BE-1:0] be    = '0;
    logic [DW-1:0] wdata = '0;
    logic [1:0]    st1, st2;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] got1_q[$], got2_q[$];
    logic          perr1_q[$], perr2_q[$];
    int            t1_q[$], t2_q[$];

    audio_nios_onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();
    audio_nios_onchip_ram_pipelined_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus2 ();

    assign bus1.chipselect = cs;
    assign bus1.read       = rd;
    assign bus1.write      = wr;
    assign bus1.address    = addr;
    assign bus1.byteenable = be;
    assign bus1.writedata  = wdata;
    assign bus2.chipselect = cs;
    assign bus2.read       = rd;
    assign bus2.write      = wr;
    assign bus2.address    = addr;
    assign bus2.byteenable = be;
    assign bus2.writedata  = wdata;

    audio_nios_onchip_ram_pipelined #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
    ) u_dut1 (.clk(clk), .reset(reset), .clken(clken), .bus(bus1), .state_dbg(st1));

    audio_nios_onchip_ram_pipelined #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1)
    ) u_dut2 (.clk(clk), .reset(reset), .clken(clken), .bus(bus2), .state_dbg(st2));

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- read-beat monitor ----------------
    always @(negedge clk) begin
        #2;
        if (bus1.readdatavalid === 1'b1) begin
            got1_q.push_back(bus1.readdata);
            perr1_q.push_back(bus1.parity_error);
            t1_q.push_back(cyc);
        end
        if (bus2.readdatavalid === 1'b1) begin
            got2_q.push_back(bus2.readdata);
            perr2_q.push_back(bus2.parity_error);
            t2_q.push_back(cyc);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive_idle();
    endtask

    task automatic drive_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [BE-1:0] b);
        @(negedge clk);
        cs    = 1'b1;
        rd    = 1'b0;
        wr    = 1'b1;
        addr  = a;
        wdata = d;
        be    = b;
    endtask

    task automatic drive_read(input logic [AW-1:0] a, output int issued);
        @(negedge clk);
        cs     = 1'b1;
        rd     = 1'b1;
        wr     = 1'b0;
        addr   = a;
        issued = cyc;
    endtask

    task automatic clear_beats();
        got1_q.delete();
        got2_q.delete();
        perr1_q.delete();
        perr2_q.delete();
        t1_q.delete();
        t2_q.delete();
        exp_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n1, n2;
        reset = 1'b1;
        idle_cycles(3);
        #1;
        tests_run++;
        if (bus1.waitrequest !== 1'b1 || bus2.waitrequest !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_wait: got %b/%b expected 1/1", bus1.waitrequest, bus2.waitrequest);
        end
        tests_run++;
        if (bus1.readdatavalid !== 1'b0 || bus2.readdatavalid !== 1'b0 || bus1.readdata !== '0 || bus2.readdata !== '0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got vld %b/%b data %h/%h expected 0/0 0/0",
                     bus1.readdatavalid, bus2.readdatavalid, bus1.readdata, bus2.readdata);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests_run++;
        if (bus1.waitrequest !== 1'b1 || bus1.readdatavalid !== 1'b0 || bus1.parity_error !== 1'b0 || st1 !== 2'd0) begin
            tests_failed++;
            $display("FAIL first_cycle: got wait %b vld %b perr %b state %0d expected 1 0 0 0",
                     bus1.waitrequest, bus1.readdatavalid, bus1.parity_error, st1);
        end
        n1 = 0;
        n2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus1.waitrequest) n1++;
            if (bus2.waitrequest) n2++;
            if (!bus1.waitrequest && !bus2.waitrequest) break;
        end
        tests_run++;
        if (n1 != DEPTH || n2 != DEPTH) begin
            tests_failed++;
            $display("FAIL clear_len: got %0d/%0d expected %0d", n1, n2, DEPTH);
        end
        tests_run++;
        if (st1 !== 2'd2 || st2 !== 2'd2) begin
            tests_failed++;
            $display("FAIL ready_state: got %0d/%0d expected 2", st1, st2);
        end
    endtask

    task automatic test_byte_lanes();
        int t;
        clear_beats();
        drive_write(16'd5, 32'hAABBCCDD, 4'hF);
        drive_write(16'd5, 32'h11223344, 4'h5);
        drive_write(16'd6, 32'hFFFFFFFF, 4'hF);
        drive_write(16'd6, 32'h00000000, 4'hA);
        drive_read(16'd5, t);
        drive_read(16'd6, t);
        idle_cycles(4);
        exp_q.push_back(32'hAA22CC44);
        exp_q.push_back(32'h00FF00FF);
        tests_run++;
        if (got1_q.size() != 2 || got2_q.size() != 2) begin
            tests_failed++;
            $display("FAIL lanes_count: got %0d/%0d expected 2", got1_q.size(), got2_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got1_q.size() || i >= got2_q.size()) begin
                tests_failed++;
                $display("FAIL lanes_data[%0d]: got missing beat expected %h", i, exp_q[i]);
            end else if (got1_q[i] !== exp_q[i] || got2_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL lanes_data[%0d]: got %h/%h expected %h", i, got1_q[i], got2_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int t0, tx;
        clear_beats();
        drive_write(16'd1, 32'hDEAD0001, 4'hF);
        drive_write(16'd2, 32'hBEEF0002, 4'hF);
        drive_write(16'd3, 32'hCAFE0003, 4'hF);
        drive_write(16'd9, 32'h0BADF00D, 4'hF);
        drive_read(16'd9, tx);
        drive_idle();
        drive_read(16'd1, t0);
        drive_read(16'd2, tx);
        drive_read(16'd3, tx);
        idle_cycles(4);
        exp_q.push_back(32'h0BADF00D);
        exp_q.push_back(32'hDEAD0001);
        exp_q.push_back(32'hBEEF0002);
        exp_q.push_back(32'hCAFE0003);
        tests_run++;
        if (got1_q.size() != 4 || got2_q.size() != 4) begin
            tests_failed++;
            $display("FAIL b2b_count: got %0d/%0d expected 4", got1_q.size(), got2_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got1_q.size() || i >= got2_q.size()) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got missing beat expected %h", i, exp_q[i]);
            end else if (got1_q[i] !== exp_q[i] || got2_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL b2b_data[%0d]: got %h/%h expected %h", i, got1_q[i], got2_q[i], exp_q[i]);
            end
        end
        for (int i = 1; i < 4; i++) begin
            tests_run++;
            if (i >= t1_q.size() || i >= t2_q.size()) begin
                tests_failed++;
                $display("FAIL b2b_timing[%0d]: got missing beat expected cycle %0d", i, t0 + i);
            end else if (t1_q[i] != t0 + i || t2_q[i] != t0 + i + 1) begin
                tests_failed++;
                $display("FAIL b2b_timing[%0d]: got cycle %0d/%0d expected %0d/%0d",
                         i, t1_q[i], t2_q[i], t0 + i, t0 + i + 1);
            end
        end
    endtask

    task automatic test_clken_stall();
        int t0;
        clear_beats();
        drive_read(16'd2, t0);
        @(negedge clk);
        cs    = 1'b0;
        rd    = 1'b0;
        clken = 1'b0;
        #1;
        tests_run++;
        if (bus1.waitrequest !== 1'b1 || bus2.waitrequest !== 1'b1 || bus1.readdatavalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL stall_wait: got wait %b/%b vld %b expected 1/1 0",
                     bus1.waitrequest, bus2.waitrequest, bus1.readdatavalid);
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        clken = 1'b1;
        idle_cycles(4);
        tests_run++;
        if (got1_q.size() != 1 || got2_q.size() != 1) begin
            tests_failed++;
            $display("FAIL stall_count: got %0d/%0d expected 1", got1_q.size(), got2_q.size());
        end else begin
            tests_run++;
            if (got1_q[0] !== 32'hBEEF0002 || got2_q[0] !== 32'hBEEF0002) begin
                tests_failed++;
                $display("FAIL stall_data: got %h/%h expected beef0002", got1_q[0], got2_q[0]);
            end
            tests_run++;
            if (t1_q[0] != t0 + 4 || t2_q[0] != t0 + 5) begin
                tests_failed++;
                $display("FAIL stall_timing: got cycle %0d/%0d expected %0d/%0d",
                         t1_q[0], t2_q[0], t0 + 4, t0 + 5);
            end
        end
    endtask

    task automatic test_edge_cases();
        int t;
        clear_beats();
        drive_write(16'd0, 32'h5A5A5A5A, 4'hF);
        drive_write(16'd4, 32'h44444444, 4'hF);
        drive_write(16'd20, 32'hFFFFFFFF, 4'hF);
        drive_read(16'd16, t);
        drive_read(16'd4, t);
        idle_cycles(4);
        exp_q.push_back(32'h00000000);
        exp_q.push_back(32'h44444444);
        tests_run++;
        if (got1_q.size() != 2 || got2_q.size() != 2) begin
            tests_failed++;
            $display("FAIL oor_count: got %0d/%0d expected 2", got1_q.size(), got2_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got1_q.size() || i >= got2_q.size()) begin
                tests_failed++;
                $display("FAIL oor_data[%0d]: got missing beat expected %h", i, exp_q[i]);
            end else if (got1_q[i] !== exp_q[i] || got2_q[i] !== exp_q[i] ||
                         perr1_q[i] !== 1'b0 || perr2_q[i] !== 1'b0) begin
                tests_failed++;
                $display("FAIL oor_data[%0d]: got %h/%h perr %b/%b expected %h perr 0",
                         i, got1_q[i], got2_q[i], perr1_q[i], perr2_q[i], exp_q[i]);
            end
        end

        clear_beats();
        @(negedge clk);
        cs    = 1'b1;
        rd    = 1'b1;
        wr    = 1'b1;
        addr  = 16'd7;
        wdata = 32'h12345678;
        be    = 4'hF;
        idle_cycles(4);
        tests_run++;
        if (got1_q.size() != 0 || got2_q.size() != 0) begin
            tests_failed++;
            $display("FAIL rdwr_novalid: got %0d/%0d beats expected 0", got1_q.size(), got2_q.size());
        end
        drive_read(16'd7, t);
        idle_cycles(4);
        tests_run++;
        if (got1_q.size() != 1 || got2_q.size() != 1) begin
            tests_failed++;
            $display("FAIL rdwr_readback: got %0d/%0d beats expected 1", got1_q.size(), got2_q.size());
        end else if (got1_q[0] !== 32'h12345678 || got2_q[0] !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL rdwr_readback: got %h/%h expected 12345678", got1_q[0], got2_q[0]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int t, n1, n2;
        for (int i = 0; i < DEPTH; i++)
            drive_write(AW'(i), 32'hA5000000 | 32'(i), 4'hF);
        clear_beats();
        drive_read(16'd1, t);
        @(negedge clk);
        cs    = 1'b0;
        rd    = 1'b0;
        reset = 1'b1;
        idle_cycles(2);
        @(negedge clk);
        reset = 1'b0;
        idle_cycles(6);
        reset = 1'b1;
        idle_cycles(2);
        tests_run++;
        if (got1_q.size() != 0 || got2_q.size() != 0) begin
            tests_failed++;
            $display("FAIL flush_inflight: got %0d/%0d beats expected 0", got1_q.size(), got2_q.size());
        end
        @(negedge clk);
        reset = 1'b0;
        n1 = 0;
        n2 = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (bus1.waitrequest) n1++;
            if (bus2.waitrequest) n2++;
            if (!bus1.waitrequest && !bus2.waitrequest) break;
        end
        tests_run++;
        if (n1 != DEPTH || n2 != DEPTH) begin
            tests_failed++;
            $display("FAIL restart_clear_len: got %0d/%0d expected %0d", n1, n2, DEPTH);
        end
        clear_beats();
        for (int i = 0; i < DEPTH; i++) begin
            drive_read(AW'(i), t);
            exp_q.push_back(32'h00000000);
        end
        idle_cycles(4);
        tests_run++;
        if (got1_q.size() != DEPTH || got2_q.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL cleared_count: got %0d/%0d expected %0d", got1_q.size(), got2_q.size(), DEPTH);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            tests_run++;
            if (i >= got1_q.size() || i >= got2_q.size()) begin
                tests_failed++;
                $display("FAIL cleared_data[%0d]: got missing beat expected %h", i, exp_q[i]);
            end else if (got1_q[i] !== exp_q[i] || got2_q[i] !== exp_q[i]) begin
                tests_failed++;
                $display("FAIL cleared_data[%0d]: got %h/%h expected %h", i, got1_q[i], got2_q[i], exp_q[i]);
            end
        end
    endtask

`ifdef AUDIO_NIOS_RAM_PARITY_EN
    task automatic test_parity();
        int t;
        clear_beats();
        drive_write(16'd3, 32'h000000F0, 4'hF);
        drive_write(16'd4, 32'h01020304, 4'hF);
        drive_idle();
        u_dut1.mem[3][0] = ~u_dut1.mem[3][0];
        u_dut2.mem[3][0] = ~u_dut2.mem[3][0];
        drive_read(16'd3, t);
        drive_read(16'd4, t);
        idle_cycles(4);
        tests_run++;
        if (perr1_q.size() != 2 || perr2_q.size() != 2) begin
            tests_failed++;
            $display("FAIL parity_count: got %0d/%0d expected 2", perr1_q.size(), perr2_q.size());
        end else begin
            tests_run++;
            if (perr1_q[0] !== 1'b1 || perr2_q[0] !== 1'b1) begin
                tests_failed++;
                $display("FAIL parity_flag: got %b/%b expected 1", perr1_q[0], perr2_q[0]);
            end
            tests_run++;
            if (perr1_q[1] !== 1'b0 || perr2_q[1] !== 1'b0) begin
                tests_failed++;
                $display("FAIL parity_clean: got %b/%b expected 0", perr1_q[1], perr2_q[1]);
            end
            tests_run++;
            if (got1_q[0] !== 32'h000000F1 || got2_q[0] !== 32'h000000F1) begin
                tests_failed++;
                $display("FAIL parity_data: got %h/%h expected 000000f1", got1_q[0], got2_q[0]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_byte_lanes();
        test_back_to_back();
        test_clken_stall();
        test_edge_cases();
        test_reset_mid_clear();
`ifdef AUDIO_NIOS_RAM_PARITY_EN
        test_parity();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        tests_run++;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
